// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//
// Two-entry pipeline register with a skid slot. The main register always
// drives the output, and the skid register catches the one entry that can
// arrive after the downstream stalls. Both ready/valid outputs are decoded from
// registered state only, so neither handshake has a combinational path through
// this block. A synchronous flush kills held and incoming entries. A saturating
// counter records the number of cycles in which the downstream stage stalled.
// -----------------------------------------------------------------------------
module pipe_skid_reg #(
    parameter int CTRL_W           = 4,
    parameter int DATA_W           = 101,
    parameter bit CTRL_BUBBLE_ZERO = 1'b1,
    parameter int CNT_W            = 16
) (
    input  logic              clk,
    input  logic              rst,        // asynchronous, active-low
    // upstream
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    // downstream
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    // status
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // The state encoding equals the number of held entries, so occupancy is
    // the state register itself.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam logic [CNT_W-1:0] STALL_MAX = '1;

    logic [1:0]        state_q,     state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic in_fire;
    logic out_fire;
    logic stalled;

    // Handshake decode: both readiness flags come straight from state_q.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign stalled   = out_valid & ~out_ready;

    // Next-state and datapath selection for the main/skid pair.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d     = ST_ONE;
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                end
            end
            ST_ONE: begin
                case ({in_fire, out_fire})
                    2'b11: begin
                        // Head leaves while the new entry takes its place.
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                    2'b10: begin
                        // Downstream stalled: park the new entry in skid.
                        state_d     = ST_FULL;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end
                    2'b01: begin
                        state_d = ST_EMPTY;
                    end
                    default: begin
                    end
                endcase
            end
            ST_FULL: begin
                // in_ready is low here, so only the output side can move.
                if (out_fire) begin
                    state_d     = ST_ONE;
                    main_ctrl_d = skid_ctrl_q;
                    main_data_d = skid_data_q;
                end
            end
            default: begin
                // Unreachable encoding: recover to a clean empty pipe.
                state_d = ST_EMPTY;
            end
        endcase

        // Flush wins over every transition. An out_fire this cycle has already
        // completed on the wire; anything accepted this cycle is dropped, and
        // the registers keep their contents so out_data holds its last value.
        if (flush) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = main_ctrl_q;
            main_data_d = main_data_q;
            skid_ctrl_d = skid_ctrl_q;
            skid_data_d = skid_data_q;
        end
    end

    // Saturating count of downstream-stall cycles; flush does not clear it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stalled && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State, payload and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            // NOTE: payload registers are reset too, so out_data and the skid
            // slot read as zero after reset rather than as unknown values.
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value of its _d, independent of statement order.
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Output drive: control is blanked during bubbles, data holds its value.
    assign out_ctrl  = (CTRL_BUBBLE_ZERO && !out_valid) ? '0 : main_ctrl_q;
    assign out_data  = main_data_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
//
// Directed scenarios followed by a long randomised run. Expected outputs come
// from a queue-based model: the pipe is a FIFO of at most two entries, the head
// is what the output shows, and the stall counter is a saturating integer.
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;

    localparam int CTRL_W    = 4;
    localparam int DATA_W    = 101;
    localparam int CNT_W     = 3;
    localparam int STALL_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } entry_t;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    pipe_skid_reg #(
        .CTRL_W           (CTRL_W),
        .DATA_W           (DATA_W),
        .CTRL_BUBBLE_ZERO (1'b1),
        .CNT_W            (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    entry_t            mdl_q[$];
    int                mdl_stall;
    logic [DATA_W-1:0] mdl_last;

    // Scoreboard for the randomised run
    bit                sb_on;
    logic [DATA_W-1:0] exp_deliv[$];
    logic [DATA_W-1:0] got_deliv[$];

    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[DATA_W-1:0];
    endfunction

    function automatic logic [CTRL_W-1:0] rnd_ctrl();
        logic [31:0] r;
        r = $urandom();
        return r[CTRL_W-1:0];
    endfunction

    task automatic model_reset();
        mdl_q.delete();
        mdl_stall = 0;
        mdl_last  = '0;
    endtask

    // One clock of the abstract pipe: deliver head if taken, then either
    // discard everything (flush) or append the offered entry if there is room.
    task automatic model_update(input logic iv, input entry_t e, input logic fl, input logic ordy);
        bit     has_room;
        entry_t head;
        has_room = (mdl_q.size() < 2);
        if (mdl_q.size() > 0 && !ordy)
            mdl_stall = (mdl_stall == STALL_MAX) ? STALL_MAX : mdl_stall + 1;
        if (mdl_q.size() > 0 && ordy) begin
            head = mdl_q.pop_front();
            if (sb_on) exp_deliv.push_back(head.d);
        end
        if (fl)
            mdl_q.delete();
        else if (iv && has_room)
            mdl_q.push_back(e);
        if (mdl_q.size() > 0)
            mdl_last = mdl_q[0].d;
    endtask

    task automatic check_outputs();
        logic [CTRL_W-1:0] exp_c;
        logic [DATA_W-1:0] exp_d;
        exp_c = (mdl_q.size() > 0) ? mdl_q[0].c : '0;
        exp_d = (mdl_q.size() > 0) ? mdl_q[0].d : mdl_last;
        check("out_valid", 128'(out_valid), 128'(mdl_q.size() > 0));
        check("in_ready",  128'(in_ready),  128'(mdl_q.size() < 2));
        check("occupancy", 128'(occupancy), 128'(mdl_q.size()));
        check("out_ctrl",  128'(out_ctrl),  128'(exp_c));
        check("out_data",  128'(out_data),  128'(exp_d));
        check("stall_cnt", 128'(stall_cnt), 128'(mdl_stall));
    endtask

    // Called at a falling edge: check, drive, clock, advance model.
    task automatic step(input logic iv, input logic [CTRL_W-1:0] ic, input logic [DATA_W-1:0] id,
                        input logic fl, input logic ordy);
        entry_t e;
        check_outputs();
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        flush     = fl;
        out_ready = ordy;
        #1;
        if (sb_on && out_valid && ordy) got_deliv.push_back(out_data);
        e.c = ic;
        e.d = id;
        @(posedge clk);
        model_update(iv, e, fl, ordy);
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, '0, '0, 1'b0, ordy);
    endtask

    initial begin
        logic [DATA_W-1:0] a [5];
        logic [DATA_W-1:0] b;
        n_vec     = 0;
        n_err     = 0;
        sb_on     = 1'b0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) a[i] = rnd_data();
        b = rnd_data();

        // Reset state, applied before the first clock edge
        #2;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;

        // Streaming: five back-to-back entries with out_ready held high
        for (int i = 0; i < 5; i++) step(1'b1, CTRL_W'(i + 1), a[i], 1'b0, 1'b1);
        check("stream_last_head", 128'(out_data), 128'(a[4]));
        idle(1'b1);
        idle(1'b1);

        // Backpressure: two entries against a stalled output, then drain
        step(1'b1, 4'h1, a[0], 1'b0, 1'b0);
        step(1'b1, 4'h2, a[1], 1'b0, 1'b0);
        check("bp_occupancy", 128'(occupancy), 128'(2));
        check("bp_in_ready",  128'(in_ready),  128'(0));
        check("bp_head",      128'(out_data),  128'(a[0]));
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        check("bp_second",    128'(out_data),  128'(a[1]));
        idle(1'b1);
        check("bp_empty",     128'(out_valid), 128'(0));

        // Flush while full with a fresh entry offered on the same cycle
        step(1'b1, 4'h3, a[2], 1'b0, 1'b0);
        step(1'b1, 4'h4, a[3], 1'b0, 1'b0);
        step(1'b1, 4'h5, b,    1'b1, 1'b0);
        check("fl_valid", 128'(out_valid), 128'(0));
        check("fl_occ",   128'(occupancy), 128'(0));
        check("fl_ctrl",  128'(out_ctrl),  128'(0));
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            check("fl_no_b", 128'(out_data == b), 128'(0));
        end

        // Asynchronous reset asserted mid-cycle while full
        step(1'b1, 4'h6, a[0], 1'b0, 1'b0);
        step(1'b1, 4'h7, a[1], 1'b0, 1'b0);
        check("ar_pre_full", 128'(occupancy), 128'(2));
        #2;
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("ar_valid",  128'(out_valid), 128'(0));
        check("ar_ready",  128'(in_ready),  128'(1));
        check("ar_stall",  128'(stall_cnt), 128'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        check_outputs();

        // Stall counter saturation, then a flush must leave it untouched
        step(1'b1, 4'h8, a[2], 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) idle(1'b0);
        check("sat_value", 128'(stall_cnt), 128'(STALL_MAX));
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("sat_after_flush", 128'(stall_cnt), 128'(STALL_MAX));
        idle(1'b1);

        // Randomised handshakes with flush low, scoreboarded
        sb_on = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), rnd_ctrl(), rnd_data(), 1'b0,
                 1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        sb_on = 1'b0;
        check("sb_count", 128'(got_deliv.size()), 128'(exp_deliv.size()));
        if (got_deliv.size() == exp_deliv.size()) begin
            for (int i = 0; i < exp_deliv.size(); i++)
                check("sb_order", 128'(got_deliv[i]), 128'(exp_deliv[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
